// File: rtl/pulse_train_gen.sv
// Pulse-train generator: N pulses of H high / L low cycles on a registered data line.
// Latency: data rises one cycle after the start edge; no backpressure, start is ignored while busy.
module pulse_train_gen #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [NUM_W-1:0] num_pulses,
    output logic             data,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] pulse_cnt
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] l_q, l_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic [NUM_W-1:0] cnt_d;
    logic             data_d, busy_d, done_d;
    logic [CNT_W-1:0] h_eff, l_eff;

    // Zero-length phases are stretched to one cycle.
    assign h_eff = (high_len == '0) ? CNT_W'(1) : high_len;
    assign l_eff = (low_len  == '0) ? CNT_W'(1) : low_len;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        h_d     = h_q;
        l_d     = l_q;
        rem_d   = rem_q;
        cnt_d   = pulse_cnt;
        data_d  = data;
        busy_d  = busy;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    h_d   = h_eff;
                    l_d   = l_eff;
                    cnt_d = '0;
                    if (num_pulses == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = HIGH;
                        data_d  = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = NUM_W'(1);
                        rem_d   = num_pulses - NUM_W'(1);
                        phase_d = h_eff - CNT_W'(1);
                    end
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_q != '0) begin
                    phase_d = phase_q - CNT_W'(1);
                end else if (rem_q != '0) begin
                    state_d = LOW;
                    data_d  = 1'b0;
                    phase_d = l_q - CNT_W'(1);
                end else begin
                    // Last pulse ends the train directly, no trailing low phase.
                    state_d = IDLE;
                    data_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            LOW: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = 1'b0;
                    busy_d  = 1'b0;
                end else if (phase_q != '0) begin
                    phase_d = phase_q - CNT_W'(1);
                end else begin
                    state_d = HIGH;
                    data_d  = 1'b1;
                    cnt_d   = pulse_cnt + NUM_W'(1);
                    rem_d   = rem_q - NUM_W'(1);
                    phase_d = h_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            h_q       <= '0;
            l_q       <= '0;
            rem_q     <= '0;
            pulse_cnt <= '0;
            data      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            h_q       <= h_d;
            l_q       <= l_d;
            rem_q     <= rem_d;
            pulse_cnt <= cnt_d;
            data      <= data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: table-driven trains, hand corner cases, random trains.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] high_len, low_len, num_pulses;
    logic       data, busy, done;
    logic [7:0] pulse_cnt;

    int tests = 0;
    int fails = 0;

    pulse_train_gen #(.CNT_W(8), .NUM_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .high_len(high_len), .low_len(low_len), .num_pulses(num_pulses),
        .data(data), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hl; int ll; int n; int abort_at; bit noisy;
        int exp_busy; int exp_cnt; bit exp_done;
    } vec_t;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: cycle k (1-based after the start edge) of a train sits at
    // position k-1 inside repeating H+L periods; the train is N*H+(N-1)*L long.
    task automatic run_train(input int hl, input int ll, input int n, input int abort_at,
                             input bit noisy, output int busy_seen, output int cnt_seen,
                             output int done_seen);
        int h, l, t, per, pos, exp_cnt, edges;
        logic prev;
        h = (hl == 0) ? 1 : hl;
        l = (ll == 0) ? 1 : ll;
        t = (n == 0) ? 0 : n * h + (n - 1) * l;
        per = h + l;
        busy_seen = 0;
        edges = 0;
        prev = data;
        high_len = 8'(hl); low_len = 8'(ll); num_pulses = 8'(n);
        start = 1'b1; abort = 1'b0;
        tick;
        start = 1'b0;
        for (int k = 1; k <= t; k++) begin
            pos = k - 1;
            exp_cnt = pos / per + 1;
            chk($sformatf("data h%0d l%0d n%0d k%0d", hl, ll, n, k), int'(data), (pos % per) < h ? 1 : 0);
            chk($sformatf("busy k%0d", k), int'(busy), 1);
            chk($sformatf("done-while-busy k%0d", k), int'(done), 0);
            chk($sformatf("pulse_cnt k%0d", k), int'(pulse_cnt), exp_cnt);
            if (busy) busy_seen++;
            if (data && !prev) edges++;
            prev = data;
            if (noisy) begin
                high_len = 8'($urandom); low_len = 8'($urandom);
                num_pulses = 8'($urandom); start = 1'($urandom);
            end
            if (k == abort_at) begin
                start = 1'b0;
                abort = 1'b1;
                tick;
                abort = 1'b0;
                chk("abort data", int'(data), 0);
                chk("abort busy", int'(busy), 0);
                chk("abort done", int'(done), 0);
                chk("abort pulse_cnt", int'(pulse_cnt), exp_cnt);
                chk("abort edge count", edges, exp_cnt);
                cnt_seen = int'(pulse_cnt);
                done_seen = int'(done);
                tick;
                chk("post-abort done", int'(done), 0);
                chk("post-abort busy", int'(busy), 0);
                return;
            end
            tick;
        end
        start = 1'b0;
        chk("end data", int'(data), 0);
        chk("end busy", int'(busy), 0);
        chk("end done", int'(done), 1);
        chk("end pulse_cnt", int'(pulse_cnt), n);
        chk("edge count", edges, n);
        cnt_seen = int'(pulse_cnt);
        done_seen = int'(done);
    endtask

    vec_t vecs[6];
    int bs, cs, ds;

    initial begin
        vecs[0] = '{2, 3, 3, 0, 1'b0, 12, 3, 1'b1};
        vecs[1] = '{0, 0, 4, 0, 1'b1, 7, 4, 1'b1};
        vecs[2] = '{5, 1, 0, 0, 1'b0, 0, 0, 1'b1};
        vecs[3] = '{4, 2, 5, 14, 1'b0, 14, 3, 1'b0};
        vecs[4] = '{255, 7, 1, 0, 1'b1, 255, 1, 1'b1};
        vecs[5] = '{1, 1, 2, 0, 1'b1, 3, 2, 1'b1};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        high_len = '0; low_len = '0; num_pulses = '0;
        tick; tick;
        rst = 1'b0;
        tick;
        chk("reset data", int'(data), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset pulse_cnt", int'(pulse_cnt), 0);

        foreach (vecs[i]) begin
            run_train(vecs[i].hl, vecs[i].ll, vecs[i].n, vecs[i].abort_at, vecs[i].noisy, bs, cs, ds);
            chk($sformatf("vec%0d busy cycles", i), bs, vecs[i].exp_busy);
            chk($sformatf("vec%0d pulse_cnt", i), cs, vecs[i].exp_cnt);
            chk($sformatf("vec%0d done", i), ds, int'(vecs[i].exp_done));
            tick;
            chk($sformatf("vec%0d done one-shot", i), int'(done), 0);
        end

        // Re-pulsed start while busy, then a new request in the done cycle.
        run_train(3, 3, 2, 0, 1'b1, bs, cs, ds);
        chk("repulse busy cycles", bs, 9);
        run_train(2, 0, 1, 0, 1'b0, bs, cs, ds);
        chk("back-to-back busy cycles", bs, 2);
        tick;

        // start and abort together in IDLE, then abort alone.
        high_len = 8'd2; num_pulses = 8'd3;
        start = 1'b1; abort = 1'b1;
        tick;
        start = 1'b0;
        chk("start+abort busy", int'(busy), 0);
        chk("start+abort data", int'(data), 0);
        chk("start+abort done", int'(done), 0);
        tick;
        abort = 1'b0;
        chk("idle abort busy", int'(busy), 0);
        chk("idle abort done", int'(done), 0);

        // Reset in the middle of a train.
        high_len = 8'd4; low_len = 8'd2; num_pulses = 8'd5;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 7; k++) tick;
        chk("pre-reset busy", int'(busy), 1);
        rst = 1'b1;
        tick;
        chk("mid reset data", int'(data), 0);
        chk("mid reset busy", int'(busy), 0);
        chk("mid reset done", int'(done), 0);
        chk("mid reset pulse_cnt", int'(pulse_cnt), 0);
        rst = 1'b0;
        tick;

        for (int r = 0; r < 30; r++) begin
            int hl, ll, n, t, ab;
            hl = $urandom_range(0, 6);
            ll = $urandom_range(0, 6);
            n  = $urandom_range(0, 5);
            t  = (n == 0) ? 0 : n * (hl == 0 ? 1 : hl) + (n - 1) * (ll == 0 ? 1 : ll);
            ab = (t > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, t) : 0;
            run_train(hl, ll, n, ab, 1'($urandom), bs, cs, ds);
            chk($sformatf("rand%0d busy cycles", r), bs, (ab != 0) ? ab : t);
            if ($urandom_range(0, 1) == 1) tick;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
